// File: rtl/fifo_write_arbiter_if.sv
// Bundle of the producer-side and FIFO-side signals of the write arbiter.
//   in_req/in_data/in_last : producer request, packed words, end-of-burst marks
//   out_grant/out_ack      : one-hot registered grant, one-hot word-consumed strobe
//   fifo_write/fifo_data   : FIFO write strobe and data
//   fifo_full              : FIFO full flag
//   out_busy               : arbiter is inside a burst
// master = arbiter side, slave = producers/FIFO side.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 4
);
  logic [NUM_REQ-1:0]           in_req;
  logic [NUM_REQ*DATA_BITS-1:0] in_data;
  logic [NUM_REQ-1:0]           in_last;
  logic [NUM_REQ-1:0]           out_grant;
  logic [NUM_REQ-1:0]           out_ack;
  logic                         fifo_write;
  logic [DATA_BITS-1:0]         fifo_data;
  logic                         fifo_full;
  logic                         out_busy;

  modport master (
    input  in_req, in_data, in_last, fifo_full,
    output out_grant, out_ack, fifo_write, fifo_data, out_busy
  );

  modport slave (
    output in_req, in_data, in_last, fifo_full,
    input  out_grant, out_ack, fifo_write, fifo_data, out_busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-aware arbiter sharing one FIFO write port among NUM_REQ
// producers. A requester holds the grant for up to MAX_BURST words, until it
// flags its last word, or until it drops its request. Writes are held off
// while the FIFO is full, so the FIFO's overwrite-oldest behaviour never
// triggers and no producer data is lost.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : fifo_write_arbiter_if master modport (see interface file)
// Parameters: NUM_REQ (2..16), DATA_BITS, MAX_BURST (1..255).
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_write_arbiter_if.master  bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  // Count only has to reach MAX_BURST-1; the cap clears it before it could wrap.
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     gidx_q, gidx_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic                 xfer;
  logic                 found;
  logic [DATA_BITS-1:0] data_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      count_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      count_q <= count_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    count_d  = count_q;
    rr_d     = rr_q;
    xfer     = 1'b0;
    found    = 1'b0;
    data_sel = '0;

    case (state_q)
      IDLE: begin
        // Scan upward from the rr pointer with wrap; first pending wins.
        for (int k = 0; k < NUM_REQ; k++) begin
          int cand;
          logic [PTR_W-1:0] cand_idx;
          cand = int'(rr_q) + k;
          if (cand >= NUM_REQ) cand = cand - NUM_REQ;
          cand_idx = PTR_W'(cand);
          if (!found && bus.in_req[cand_idx]) begin
            found             = 1'b1;
            gidx_d            = cand_idx;
            grant_d           = '0;
            grant_d[cand_idx] = 1'b1;
            count_d           = '0;
            state_d           = BURST;
          end
        end
      end

      BURST: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (PTR_W'(i) == gidx_q) data_sel = bus.in_data[i*DATA_BITS +: DATA_BITS];
        end
        xfer = bus.in_req[gidx_q] & ~bus.fifo_full;
        // A full FIFO with the request still up just freezes everything.
        if (!bus.in_req[gidx_q] ||
            (xfer && (bus.in_last[gidx_q] || count_q == CNT_LAST))) begin
          state_d = IDLE;
          grant_d = '0;
          count_d = '0;
          rr_d    = (gidx_q == PTR_LAST) ? '0 : gidx_q + PTR_W'(1);
        end else if (xfer) begin
          count_d = count_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.out_grant  = grant_q;
  assign bus.out_ack    = grant_q & {NUM_REQ{xfer}};
  assign bus.fifo_write = xfer;
  assign bus.fifo_data  = data_sel;
  assign bus.out_busy   = (state_q == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios followed by a
// randomized run, all compared each cycle against a burst-level model.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DB = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_BITS(DB)) bus ();

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests   = 0;
  int fails   = 0;
  int wr_seen = 0;

  // Reference model: who owns the port, how many words it has written in
  // this burst, and where the next idle scan starts.
  bit m_busy;
  int m_g;
  int m_words;
  int m_rr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DB-1:0] word_of(input int i);
    logic [NR*DB-1:0] t;
    t = bus.in_data >> (i * DB);
    return t[DB-1:0];
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_g     = 0;
    m_words = 0;
    m_rr    = 0;
  endtask

  task automatic apply_stimulus(input logic [NR-1:0] req, input logic [NR*DB-1:0] data,
                                input logic [NR-1:0] last, input logic full);
    bus.in_req    = req;
    bus.in_data   = data;
    bus.in_last   = last;
    bus.fifo_full = full;
  endtask

  task automatic check_output();
    bit xfer;
    logic [31:0] eg;
    xfer = m_busy && bus.in_req[m_g] && !bus.fifo_full;
    eg   = m_busy ? (32'd1 << m_g) : 32'd0;
    check_val("grant", {28'd0, bus.out_grant}, eg);
    check_val("ack", {28'd0, bus.out_ack}, xfer ? eg : 32'd0);
    check_val("write", {31'd0, bus.fifo_write}, {31'd0, xfer});
    check_val("data", {28'd0, bus.fifo_data}, m_busy ? {28'd0, word_of(m_g)} : 32'd0);
    check_val("busy", {31'd0, bus.out_busy}, {31'd0, m_busy});
    if (bus.fifo_write === 1'b1) wr_seen++;
  endtask

  // One clock: check just after the falling edge, step the model at the
  // rising edge with the inputs that were present, return at the next fall.
  task automatic tick();
    logic [NR-1:0] req, last;
    logic full, rst;
    #1;
    check_output();
    req  = bus.in_req;
    last = bus.in_last;
    full = bus.fifo_full;
    rst  = reset;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_rr + k) % NR;
        if (req[idx]) begin
          m_busy  = 1'b1;
          m_g     = idx;
          m_words = 0;
          break;
        end
      end
    end else if (!req[m_g]) begin
      m_busy = 1'b0;
      m_rr   = (m_g + 1) % NR;
    end else if (!full) begin
      m_words++;
      if (last[m_g] || m_words == MB) begin
        m_busy = 1'b0;
        m_rr   = (m_g + 1) % NR;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply_stimulus('0, '0, '0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic go_idle();
    apply_stimulus('0, '0, '0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int wr0;
    int grants[$];
    logic [NR-1:0] prev;
    logic [31:0] exp_order [5];

    model_reset();
    reset = 1'b1;
    apply_stimulus('0, '0, '0, 1'b0);
    @(negedge clk);

    // Reset state.
    tick();
    check_val("rst_grant", {28'd0, bus.out_grant}, 32'd0);
    check_val("rst_busy", {31'd0, bus.out_busy}, 32'd0);
    reset = 1'b0;

    // Single-word burst from requester 1.
    $display("[TB] single word burst");
    apply_stimulus(4'b0010, 16'h00A0, 4'b0010, 1'b0);
    tick();
    check_val("t1_grant", {28'd0, bus.out_grant}, 32'h2);
    check_val("t1_write", {31'd0, bus.fifo_write}, 32'd1);
    check_val("t1_data", {28'd0, bus.fifo_data}, 32'hA);
    tick();
    apply_stimulus('0, '0, '0, 1'b0);
    tick();
    check_val("t1_idle", {31'd0, bus.out_busy}, 32'd0);
    // rr pointer now 2: requesters 0 and 1 pending, scan 2,3,0 picks 0.
    apply_stimulus(4'b0011, 16'h0000, '0, 1'b0);
    tick();
    check_val("t1_rr", {28'd0, bus.out_grant}, 32'h1);
    go_idle();

    // Everyone requesting, no last flags: full-length bursts in rotation.
    $display("[TB] round robin bursts");
    do_reset();
    apply_stimulus(4'b1111, 16'h4321, '0, 1'b0);
    wr0  = wr_seen;
    prev = '0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus.out_grant !== prev && bus.out_grant != '0) begin
        for (int i = 0; i < NR; i++) if (bus.out_grant[i]) grants.push_back(i);
      end
      prev = bus.out_grant;
    end
    exp_order = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    check_val("t2_nbursts", grants.size(), 32'd5);
    for (int i = 0; i < grants.size() && i < 5; i++) check_val("t2_order", grants[i], exp_order[i]);
    check_val("t2_words", wr_seen - wr0, 32'd20);
    go_idle();

    // FIFO full for three cycles in the middle of requester 2's burst.
    $display("[TB] full stall mid burst");
    apply_stimulus(4'b0100, 16'h0B00, '0, 1'b0);
    wr0 = wr_seen;
    tick();
    tick();
    tick();
    apply_stimulus(4'b0100, 16'h0B00, '0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_val("t3_stall_write", {31'd0, bus.fifo_write}, 32'd0);
      check_val("t3_stall_ack", {28'd0, bus.out_ack}, 32'd0);
      check_val("t3_stall_grant", {28'd0, bus.out_grant}, 32'h4);
      tick();
    end
    apply_stimulus(4'b0100, 16'h0B00, '0, 1'b0);
    for (int c = 0; c < 10 && bus.out_busy === 1'b1; c++) tick();
    check_val("t3_words", wr_seen - wr0, 32'd4);
    check_val("t3_done", {31'd0, bus.out_busy}, 32'd0);
    go_idle();

    // Requester 0 abandons after two words.
    $display("[TB] abandoned burst");
    apply_stimulus(4'b0001, 16'h0007, '0, 1'b0);
    wr0 = wr_seen;
    tick();
    tick();
    tick();
    apply_stimulus(4'b1000, 16'h0007, '0, 1'b0);
    tick();
    check_val("t4_words", wr_seen - wr0, 32'd2);
    check_val("t4_idle", {31'd0, bus.out_busy}, 32'd0);
    apply_stimulus(4'b1001, 16'h5007, '0, 1'b0);
    tick();
    check_val("t4_next", {28'd0, bus.out_grant}, 32'h8);
    go_idle();

    // Asynchronous reset between edges in the middle of a burst.
    $display("[TB] async reset mid burst");
    apply_stimulus(4'b0100, 16'h0C00, '0, 1'b0);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_val("t5_grant", {28'd0, bus.out_grant}, 32'd0);
    check_val("t5_write", {31'd0, bus.fifo_write}, 32'd0);
    check_val("t5_busy", {31'd0, bus.out_busy}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(4'b1010, 16'h0000, '0, 1'b0);
    tick();
    check_val("t5_restart", {28'd0, bus.out_grant}, 32'h2);
    go_idle();

    // FIFO permanently full: grant is held, nothing is written.
    $display("[TB] fifo always full");
    apply_stimulus(4'b0001, 16'h0009, '0, 1'b1);
    wr0 = wr_seen;
    for (int c = 0; c < 12; c++) tick();
    check_val("t6_words", wr_seen - wr0, 32'd0);
    check_val("t6_grant", {28'd0, bus.out_grant}, 32'h1);
    go_idle();

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      apply_stimulus(NR'($urandom), (NR*DB)'($urandom), NR'($urandom & $urandom),
                     ($urandom_range(0, 3) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
